// File: rtl/wb_master_pkg.sv
// wb_master_pkg: shared FSM state type, CTI encodings and CTI selection helper for the Wishbone burst master
package wb_master_pkg;
   typedef enum logic [1:0] {IDLE, WR_WAIT, BUS} state_t;
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;
   function automatic logic [2:0] cti_of(input logic single, input logic last);
      return single ? CTI_CLASSIC : last ? CTI_EOB : CTI_INCR;
   endfunction
endpackage

// File: rtl/wbm_beat_gen.sv
// wbm_beat_gen: beat counter, wrapping address incrementer and CTI / last-beat generation
// Ports: i_clk, i_rst_n (sync active-low); i_load latches i_addr/i_len at command accept;
//        i_step advances one beat on ack; i_clr ends the cycle (CTI back to classic);
//        o_addr/o_cti are registered Wishbone address/CTI, o_last flags the final beat.
module wbm_beat_gen
   import wb_master_pkg::*;
#(
   parameter int AW = 26,
   parameter int LW = 4
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_load,
   input  logic          i_step,
   input  logic          i_clr,
   input  logic [AW-1:0] i_addr,
   input  logic [LW-1:0] i_len,
   output logic [AW-1:0] o_addr,
   output logic [2:0]    o_cti,
   output logic          o_last
);
   logic [LW-1:0] r_beat, r_len, w_beat, w_len;
   logic [AW-1:0] r_addr;
   logic [2:0]    r_cti;
   // CTI is computed for the beat that becomes current after this edge
   assign w_len  = i_load ? i_len : r_len;
   assign w_beat = i_load ? '0 : r_beat + 1'b1;
   assign o_last = r_beat == r_len;
   assign o_addr = r_addr;
   assign o_cti  = r_cti;
   always_ff @(posedge i_clk)
      if (!i_rst_n) begin
         r_beat <= '0;
         r_len  <= '0;
         r_addr <= '0;
         r_cti  <= CTI_CLASSIC;
      end else if (i_clr) begin
         r_beat <= '0;
         r_len  <= '0;
         r_cti  <= CTI_CLASSIC;
      end else if (i_load || i_step) begin
         r_beat <= w_beat;
         r_len  <= w_len;
         r_cti  <= cti_of(w_len == '0, w_beat == w_len);
         r_addr <= i_load ? i_addr : r_addr + 1'b1;
      end
endmodule

// File: rtl/wb_burst_master.sv
// wb_burst_master: turns one command into a single or incrementing-burst Wishbone cycle
// Ports: sys_clk/RESETN (sync active-low); cmd_* command handshake (len = beats-1, sel on every beat);
//        wdat_* write-beat handshake; rd_valid/rd_data read beats; done/err completion pulses;
//        wb_* registered Wishbone initiator outputs, wb_dat_i/wb_ack_i slave responses.
// Build option: define WBM_TIMEOUT_EN to abort a cycle after TIMEOUT_CYC cycles without ack;
//        otherwise err is tied low and the master waits indefinitely.
module wb_burst_master
   import wb_master_pkg::*;
#(
   parameter int dw          = 32,
   parameter int AW          = 26,
   parameter int MAX_LEN     = 16,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                       sys_clk,
   input  logic                       RESETN,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_we,
   input  logic [AW-1:0]              cmd_addr,
   input  logic [$clog2(MAX_LEN)-1:0] cmd_len,
   input  logic [dw/8-1:0]            cmd_sel,
   input  logic                       wdat_valid,
   output logic                       wdat_ready,
   input  logic [dw-1:0]              wdat,
   output logic                       rd_valid,
   output logic [dw-1:0]              rd_data,
   output logic                       done,
   output logic                       err,
   output logic                       wb_cyc_o,
   output logic                       wb_stb_o,
   output logic                       wb_we_o,
   output logic [AW-1:0]              wb_addr_o,
   output logic [dw-1:0]              wb_dat_o,
   output logic [dw/8-1:0]            wb_sel_o,
   output logic [2:0]                 wb_cti_o,
   input  logic [dw-1:0]              wb_dat_i,
   input  logic                       wb_ack_i
);
   localparam int LW = $clog2(MAX_LEN);
   state_t r_state, w_next;
   logic w_ack, w_last, w_to, w_accept, w_step, w_end;
   logic r_cyc, r_stb, r_we, r_rd_valid, r_done, r_err;
   logic [dw/8-1:0] r_sel;
   logic [dw-1:0]   r_dat, r_rd_data;
   // an ack only counts while the strobe is actually presented
   assign w_ack = wb_ack_i & r_stb;
`ifdef WBM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC);
   logic [TW-1:0] r_to;
   always_ff @(posedge sys_clk)
      r_to <= (!RESETN || !r_cyc || w_ack) ? '0 : r_to + 1'b1;
   assign w_to = r_cyc && !w_ack && r_to == TW'(TIMEOUT_CYC - 1);
`else
   assign w_to = 1'b0 & (TIMEOUT_CYC > 0);
`endif
   always_ff @(posedge sys_clk)
      r_state <= !RESETN ? IDLE : w_next;
   always_comb begin
      w_next = r_state;
      if (r_state == IDLE)
         w_next = cmd_valid ? (cmd_we ? WR_WAIT : BUS) : IDLE;
      else if (w_to)
         w_next = IDLE;
      else if (r_state == WR_WAIT)
         w_next = wdat_valid ? BUS : WR_WAIT;
      else if (w_ack)
         w_next = w_last ? IDLE : (!r_we || wdat_valid) ? BUS : WR_WAIT;
   end
   // a write burst either streams the next beat in the ack cycle or parks in WR_WAIT
   always_comb begin
      cmd_ready  = r_state == IDLE;
      w_accept   = cmd_ready && cmd_valid;
      w_step     = r_state == BUS && w_ack && !w_last;
      wdat_ready = wdat_valid && !w_to && (r_state == WR_WAIT || (w_step && r_we));
      w_end      = r_state != IDLE && w_next == IDLE;
   end
   always_ff @(posedge sys_clk)
      if (!RESETN) begin
         r_cyc      <= 1'b0;
         r_stb      <= 1'b0;
         r_we       <= 1'b0;
         r_sel      <= '0;
         r_dat      <= '0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_cyc      <= w_next != IDLE;
         r_stb      <= w_next == BUS;
         r_we       <= w_accept ? cmd_we : r_we;
         r_sel      <= w_accept ? cmd_sel : r_sel;
         r_dat      <= wdat_ready ? wdat : r_dat;
         r_rd_valid <= w_ack && !r_we;
         r_rd_data  <= (w_ack && !r_we) ? wb_dat_i : r_rd_data;
         r_done     <= w_ack && w_last;
         r_err      <= w_to;
      end
   wbm_beat_gen #(.AW(AW), .LW(LW)) u_beat (
      .i_clk   (sys_clk),
      .i_rst_n (RESETN),
      .i_load  (w_accept),
      .i_step  (w_step),
      .i_clr   (w_end),
      .i_addr  (cmd_addr),
      .i_len   (cmd_len),
      .o_addr  (wb_addr_o),
      .o_cti   (wb_cti_o),
      .o_last  (w_last)
   );
   assign wb_cyc_o = r_cyc;
   assign wb_stb_o = r_stb;
   assign wb_we_o  = r_we;
   assign wb_sel_o = r_sel;
   assign wb_dat_o = r_dat;
   assign rd_valid = r_rd_valid;
   assign rd_data  = r_rd_data;
   assign done     = r_done;
   assign err      = r_err;
endmodule

// File: tb/tb_wb_burst_master.sv
// tb_wb_burst_master: directed self-checking bench for wb_burst_master
module tb_wb_burst_master;
   logic        sys_clk = 1'b0;
   logic        RESETN = 1'b0;
   logic        cmd_valid = 1'b0, cmd_we = 1'b0;
   logic [25:0] cmd_addr = '0;
   logic [3:0]  cmd_len = '0;
   logic [3:0]  cmd_sel = '0;
   logic        wdat_valid = 1'b0;
   logic [31:0] wdat = '0, wb_dat_i = '0;
   logic        wb_ack_i = 1'b0;
   logic        cmd_ready, wdat_ready, rd_valid, done, err, wb_cyc_o, wb_stb_o, wb_we_o;
   logic [31:0] rd_data, wb_dat_o;
   logic [25:0] wb_addr_o;
   logic [3:0]  wb_sel_o;
   logic [2:0]  wb_cti_o;
   int errors = 0, checks = 0;

   always #5 sys_clk = ~sys_clk;

   wb_burst_master #(.dw(32), .AW(26), .MAX_LEN(16), .TIMEOUT_CYC(16)) dut (
      .sys_clk(sys_clk), .RESETN(RESETN), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
      .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
      .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o),
      .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o),
      .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
   );

   task automatic issue(input logic we, input logic [25:0] a, input logic [3:0] l, input logic [3:0] s);
      @(negedge sys_clk);
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = l; cmd_sel = s;
      @(negedge sys_clk);
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      RESETN = 1'b0;
      repeat (2) @(negedge sys_clk);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
      checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o, done, err, rd_valid, wdat_ready} !== 7'b0) begin errors++; $display("FAIL reset_flags: got cyc=%b stb=%b we=%b done=%b err=%b rdv=%b wrdy=%b want all 0", wb_cyc_o, wb_stb_o, wb_we_o, done, err, rd_valid, wdat_ready); end
      checks++; if (wb_addr_o !== 26'h0 || wb_sel_o !== 4'h0 || wb_cti_o !== 3'b000 || wb_dat_o !== 32'h0) begin errors++; $display("FAIL reset_bus: got addr=%h sel=%h cti=%b dat=%h want 0", wb_addr_o, wb_sel_o, wb_cti_o, wb_dat_o); end
      RESETN = 1'b1;
   endtask

   task automatic test_single_write();
      wdat = 32'hDEADBEEF; wdat_valid = 1'b1;
      issue(1'b1, 26'h0000100, 4'd0, 4'hF);
      checks++; if ({wb_cyc_o, wb_stb_o, wdat_ready} !== 3'b101) begin errors++; $display("FAIL sw_wait: got cyc/stb/wrdy=%b%b%b want 101", wb_cyc_o, wb_stb_o, wdat_ready); end
      @(negedge sys_clk);
      wdat_valid = 1'b0;
      checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b111) begin errors++; $display("FAIL sw_bus: got cyc/stb/we=%b%b%b want 111", wb_cyc_o, wb_stb_o, wb_we_o); end
      checks++; if (wb_addr_o !== 26'h0000100) begin errors++; $display("FAIL sw_addr: got %h want 0000100", wb_addr_o); end
      checks++; if (wb_cti_o !== 3'b000) begin errors++; $display("FAIL sw_cti: got %b want 000", wb_cti_o); end
      checks++; if (wb_dat_o !== 32'hDEADBEEF || wb_sel_o !== 4'hF) begin errors++; $display("FAIL sw_dat: got dat=%h sel=%h want deadbeef f", wb_dat_o, wb_sel_o); end
      @(negedge sys_clk);
      checks++; if (wb_stb_o !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL sw_hold: got stb=%b done=%b want 1 0", wb_stb_o, done); end
      @(negedge sys_clk);
      wb_ack_i = 1'b1;
      @(negedge sys_clk);
      wb_ack_i = 1'b0;
      checks++; if ({done, wb_cyc_o, wb_stb_o, cmd_ready} !== 4'b1001) begin errors++; $display("FAIL sw_done: got done/cyc/stb/rdy=%b%b%b%b want 1001", done, wb_cyc_o, wb_stb_o, cmd_ready); end
      @(negedge sys_clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL sw_done_pulse: got %b want 0", done); end
   endtask

   task automatic test_read_burst();
      logic [25:0] ea [4] = '{26'h3FFFFFE, 26'h3FFFFFF, 26'h0000000, 26'h0000001};
      logic [2:0]  ec [4] = '{3'b010, 3'b010, 3'b010, 3'b111};
      issue(1'b0, 26'h3FFFFFE, 4'd3, 4'hF);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge sys_clk);
         checks++; if (wb_stb_o !== 1'b1 || wb_addr_o !== ea[i]) begin errors++; $display("FAIL rb_addr[%0d]: got stb=%b addr=%h want stb=1 addr=%h", i, wb_stb_o, wb_addr_o, ea[i]); end
         checks++; if (wb_cti_o !== ec[i]) begin errors++; $display("FAIL rb_cti[%0d]: got %b want %b", i, wb_cti_o, ec[i]); end
         checks++; if (rd_valid !== (i > 0) || done !== 1'b0) begin errors++; $display("FAIL rb_rdv[%0d]: got rdv=%b done=%b want %b 0", i, rd_valid, done, i > 0); end
         if (i > 0) begin
            checks++; if (rd_data !== 32'(32'h11 * i)) begin errors++; $display("FAIL rb_data[%0d]: got %h want %h", i, rd_data, 32'(32'h11 * i)); end
         end
         wb_ack_i = 1'b1; wb_dat_i = 32'(32'h11 * (i + 1));
      end
      @(negedge sys_clk);
      wb_ack_i = 1'b0;
      checks++; if ({rd_valid, done, wb_cyc_o, wb_stb_o} !== 4'b1100) begin errors++; $display("FAIL rb_last: got rdv/done/cyc/stb=%b%b%b%b want 1100", rd_valid, done, wb_cyc_o, wb_stb_o); end
      checks++; if (rd_data !== 32'h44) begin errors++; $display("FAIL rb_last_data: got %h want 00000044", rd_data); end
      @(negedge sys_clk);
      checks++; if (rd_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rb_quiet: got rdv=%b done=%b want 0 0", rd_valid, done); end
   endtask

   task automatic test_write_gap();
      int beat = 0, nd = 0, hold = 3, gap = 0;
      issue(1'b1, 26'h0000200, 4'd7, 4'hF);
      for (int c = 0; c < 60 && beat < 8; c++) begin
         if (c > 0) @(negedge sys_clk);
         if (wb_stb_o) begin
            checks++; if (wb_dat_o !== 32'hA5000000 + 32'(beat)) begin errors++; $display("FAIL wg_dat[%0d]: got %h want %h", beat, wb_dat_o, 32'hA5000000 + 32'(beat)); end
            checks++; if (wb_addr_o !== 26'h200 + 26'(beat)) begin errors++; $display("FAIL wg_addr[%0d]: got %h want %h", beat, wb_addr_o, 26'h200 + 26'(beat)); end
            checks++; if (wb_cti_o !== (beat == 7 ? 3'b111 : 3'b010)) begin errors++; $display("FAIL wg_cti[%0d]: got %b want %b", beat, wb_cti_o, beat == 7 ? 3'b111 : 3'b010); end
            beat++;
         end else begin
            checks++; if (wb_cyc_o !== 1'b1) begin errors++; $display("FAIL wg_cyc_held: got %b want 1", wb_cyc_o); end
            if (beat > 0) gap++;
         end
         wb_ack_i = 1'b1;
         if (nd == 4 && hold > 0) begin
            wdat_valid = 1'b0; hold--;
         end else begin
            wdat_valid = nd < 8; wdat = 32'hA5000000 + 32'(nd);
         end
         #1;
         if (wdat_ready) nd++;
      end
      @(negedge sys_clk);
      wb_ack_i = 1'b0; wdat_valid = 1'b0;
      checks++; if (beat != 8) begin errors++; $display("FAIL wg_acks: got %0d want 8", beat); end
      checks++; if (gap != 3) begin errors++; $display("FAIL wg_gap: got %0d stb-low cycles want 3", gap); end
      checks++; if ({done, wb_cyc_o} !== 2'b10) begin errors++; $display("FAIL wg_done: got done/cyc=%b%b want 10", done, wb_cyc_o); end
   endtask

   task automatic test_byte_mask();
      int beat = 0;
      wdat = 32'h12345678; wdat_valid = 1'b1;
      issue(1'b1, 26'h0000040, 4'd1, 4'b0101);
      for (int c = 0; c < 20 && beat < 2; c++) begin
         if (c > 0) @(negedge sys_clk);
         if (wb_stb_o) begin
            checks++; if (wb_sel_o !== 4'b0101) begin errors++; $display("FAIL bm_sel[%0d]: got %b want 0101", beat, wb_sel_o); end
            checks++; if (wb_addr_o !== 26'h40 + 26'(beat)) begin errors++; $display("FAIL bm_addr[%0d]: got %h want %h", beat, wb_addr_o, 26'h40 + 26'(beat)); end
            beat++;
            wb_ack_i = 1'b1;
         end else wb_ack_i = 1'b0;
      end
      @(negedge sys_clk);
      wb_ack_i = 1'b0; wdat_valid = 1'b0;
      checks++; if (beat != 2 || done !== 1'b1) begin errors++; $display("FAIL bm_done: got beats=%0d done=%b want 2 1", beat, done); end
   endtask

   task automatic test_reset_mid_burst();
      issue(1'b0, 26'h0000010, 4'd7, 4'hF);
      wb_ack_i = 1'b1; wb_dat_i = 32'hA1;
      @(negedge sys_clk);
      wb_dat_i = 32'hA2;
      checks++; if (rd_valid !== 1'b1 || rd_data !== 32'hA1) begin errors++; $display("FAIL rm_beat: got rdv=%b data=%h want 1 000000a1", rd_valid, rd_data); end
      @(negedge sys_clk);
      wb_ack_i = 1'b0; RESETN = 1'b0;
      @(negedge sys_clk);
      checks++; if ({wb_cyc_o, wb_stb_o, cmd_ready, done, err, rd_valid} !== 6'b001000) begin errors++; $display("FAIL rm_reset: got cyc/stb/rdy/done/err/rdv=%b%b%b%b%b%b want 001000", wb_cyc_o, wb_stb_o, cmd_ready, done, err, rd_valid); end
      RESETN = 1'b1;
      @(negedge sys_clk);
      checks++; if (done !== 1'b0 || wb_cyc_o !== 1'b0) begin errors++; $display("FAIL rm_after: got done=%b cyc=%b want 0 0", done, wb_cyc_o); end
   endtask

   task automatic test_timeout();
`ifdef WBM_TIMEOUT_EN
      int n = 0;
      issue(1'b0, 26'h0000077, 4'd0, 4'hF);
      while (wb_cyc_o && n < 40) begin
         n++;
         @(negedge sys_clk);
      end
      checks++; if (n != 16) begin errors++; $display("FAIL to_cycles: got cyc high %0d cycles want 16", n); end
      checks++; if ({err, done, wb_cyc_o, wb_stb_o, wb_cti_o} !== 7'b1000000) begin errors++; $display("FAIL to_err: got err/done/cyc/stb=%b%b%b%b cti=%b want 1000 000", err, done, wb_cyc_o, wb_stb_o, wb_cti_o); end
      @(negedge sys_clk);
      checks++; if (err !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL to_pulse: got err=%b rdy=%b want 0 1", err, cmd_ready); end
`else
      logic seen = 1'b0;
      issue(1'b0, 26'h0000077, 4'd0, 4'hF);
      repeat (40) begin
         @(negedge sys_clk);
         seen |= err;
      end
      checks++; if ({wb_cyc_o, wb_stb_o} !== 2'b11) begin errors++; $display("FAIL to_wait: got cyc/stb=%b%b want 11", wb_cyc_o, wb_stb_o); end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL to_no_err: got err seen=%b want 0", seen); end
      RESETN = 1'b0;
      @(negedge sys_clk);
      RESETN = 1'b1;
      checks++; if (cmd_ready !== 1'b1 || wb_cyc_o !== 1'b0) begin errors++; $display("FAIL to_recover: got rdy=%b cyc=%b want 1 0", cmd_ready, wb_cyc_o); end
`endif
   endtask

   task automatic test_back_to_back();
      issue(1'b0, 26'h0000005, 4'd0, 4'hF);
      checks++; if (wb_stb_o !== 1'b1 || wb_addr_o !== 26'h5 || wb_cti_o !== 3'b000) begin errors++; $display("FAIL bb_first: got stb=%b addr=%h cti=%b want 1 0000005 000", wb_stb_o, wb_addr_o, wb_cti_o); end
      wb_ack_i = 1'b1; wb_dat_i = 32'hCAFEF00D;
      @(negedge sys_clk);
      wb_ack_i = 1'b0;
      checks++; if ({done, rd_valid} !== 2'b11 || rd_data !== 32'hCAFEF00D) begin errors++; $display("FAIL bb_done: got done/rdv=%b%b data=%h want 11 cafef00d", done, rd_valid, rd_data); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bb_ready: got %b want 1", cmd_ready); end
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 26'h0000006; cmd_len = 4'd0;
      @(negedge sys_clk);
      cmd_valid = 1'b0;
      checks++; if (wb_stb_o !== 1'b1 || wb_addr_o !== 26'h6) begin errors++; $display("FAIL bb_second: got stb=%b addr=%h want 1 0000006", wb_stb_o, wb_addr_o); end
      wb_ack_i = 1'b1; wb_dat_i = 32'h0000600D;
      @(negedge sys_clk);
      wb_ack_i = 1'b0;
      checks++; if (done !== 1'b1 || rd_data !== 32'h0000600D) begin errors++; $display("FAIL bb_second_done: got done=%b data=%h want 1 0000600d", done, rd_data); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_read_burst();
      test_write_gap();
      test_byte_mask();
      test_reset_mid_burst();
      test_timeout();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion want finish before 100000 time units");
      $fatal(1, "simulation time limit reached");
   end
endmodule
